bitstream_decimator: RTL and testbench
======================================

Name: bitstream_decimator

Overview:
- Converts a 1-bit sigma-delta bitstream into a 16-bit signed level.
- Output is a sliding-window (boxcar) count of '1' bits over the last WINDOW input samples, updated every clock.
- Sits directly after the sigma-delta modulator output. Used as the reconstruction/measurement path for the DAC loop.

Parameters:
- WINDOW, 256, number of bitstream samples summed; must be a power of two, range 4..1024.
- OUT_W, 16, width of dec_out; must be at least log2(WINDOW)+2.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  reset; synchronous, ACTIVE-HIGH. The port keeps the codebase name rst_n, but the level 1 resets.
- stream_in  input  1  sigma-delta bitstream, one sample per clock.
- dec_out  output  OUT_W (signed)  filtered level, registered.

Behaviour:
- Reset: on a rising edge with rst_n==1:
  - delay line cleared to all 0;
  - running sum cleared to 0;
  - dec_out = 0.
  - stream_in is ignored during reset.
- Delay line: WINDOW-deep 1-bit shift register. Each non-reset edge shifts in stream_in; the oldest bit falls out.
- Running sum, each non-reset edge: sum_next = sum + stream_in - oldest_bit.
  - oldest_bit is the bit leaving the line on this edge.
  - The sum is an unsigned counter of width log2(WINDOW)+1, range 0..WINDOW.
- Output: dec_out <= zero-extended sum_next, in default (unipolar) mode.
  - Latency: the bit sampled at edge n affects dec_out immediately after edge n (one register stage).
- Step property: dec_out changes by at most ±1 per clock, so a ramp passes through every intermediate integer. Benches may wait for an exact value.
- Steady state: dec_out ≈ density × WINDOW.
  - With WINDOW=256 and a modulator input of +0.5 FS (0x4000), the '1' density is 0.75.
  - dec_out settles at 191..193 and first reaches 191 within 260 clocks after reset release.
- Boundaries:
  - All-ones input saturates at exactly WINDOW (256), no wrap.
  - All-zeros input yields 0.
  - Simultaneous new=1 and oldest=1 leaves the sum unchanged.
- Reset mid-operation: next edge clears everything. The history refills from zero.
- No handshake; output valid every cycle after reset.

Optional Feature:
- Macro: DECIMATOR_BIPOLAR_EN.
- Defined: dec_out = 2*sum_next - WINDOW as a signed value, range -WINDOW..+WINDOW.
  - Reset value is still 0.
  - Steps are ±2 per clock.
- Undefined (default): unipolar count 0..WINDOW as described above.

Decomposition:
- Package decimator_pkg holds:
  - DEFAULT_WINDOW = 256;
  - DEFAULT_OUT_W = 16;
  - a function returning the sum width log2(WINDOW)+1.
- One natural sub-module: bit_delay_line.
  - WINDOW-deep 1-bit shift register with synchronous active-high clear.
  - Exposes the oldest bit.
- Top level holds the sum register and the output register.

Test Plan:
- Reset: drive stream_in=1 with rst_n=1 for 5 clocks -> dec_out stays 0. Release -> dec_out = 1 after the first edge.
- Constant ones: after reset release, 256 clocks of 1 -> dec_out ramps 1..256 by +1 per clock, then holds at 256 with no wrap.
- Constant zeros after full: from 256, feed 0 -> dec_out decrements by 1 per clock to 0 in 256 clocks.
- Pattern 1110 repeated: after 256 clocks -> dec_out = 192 exactly. Thereafter it stays within 191..193; the value 191 is hit during the ramp.
- Sigma-delta loop: modulator input 0x4000 -> dec_out == 191 within 300 clocks of reset release. Timeout at 1000 clocks fails the test.
- Mid-run reset: assert rst_n=1 for 1 clock at dec_out=150 -> dec_out=0 next edge. The ramp restarts from 0 (no stale history).

Source files
------------

// File: rtl/decimator_pkg.sv
// decimator_pkg
// Shared defaults and helpers for the bitstream decimator slice.
//   DEFAULT_WINDOW : default boxcar length in bitstream samples
//   DEFAULT_OUT_W  : default width of the filtered level output
//   sum_width()    : width of the running-sum counter for a given window
package decimator_pkg;

  localparam int DEFAULT_WINDOW = 256;
  localparam int DEFAULT_OUT_W  = 16;

  // The sum must hold 0..WINDOW inclusive, so one bit beyond log2(WINDOW).
  function automatic int sum_width(input int window);
    return $clog2(window) + 1;
  endfunction

endpackage

// File: rtl/bit_delay_line.sv
// bit_delay_line
// WINDOW-deep 1-bit shift register that exposes the bit about to leave it.
// Ports:
//   clk    : system clock, rising edge
//   clr    : synchronous active-high clear (whole line to 0)
//   din    : new bit shifted in each non-clear edge
//   oldest : bit that leaves the line on the next non-clear edge
module bit_delay_line
  import decimator_pkg::*;
#(
  parameter int WINDOW = DEFAULT_WINDOW
) (
  input  logic clk,
  input  logic clr,
  input  logic din,
  output logic oldest
);

  logic [WINDOW-1:0] line_p0;

  // Stage p0: history register, newest bit at index 0
  always_ff @(posedge clk) begin
    if (clr) begin
      line_p0 <= '0;
    end else begin
      line_p0 <= {line_p0[WINDOW-2:0], din};
    end
  end

  assign oldest = line_p0[WINDOW-1];

endmodule

// File: rtl/bitstream_decimator.sv
// bitstream_decimator
// Boxcar decimator: counts '1' bits over the last WINDOW bitstream samples
// and presents the count as a registered signed level, updated every clock.
// Ports:
//   clk       : system clock, rising edge
//   rst_n     : synchronous reset, ACTIVE-HIGH despite the name (1 resets)
//   stream_in : sigma-delta bitstream, one sample per clock
//   dec_out   : filtered level (signed, OUT_W bits), one register stage
// Build option:
//   DECIMATOR_BIPOLAR_EN : when defined, dec_out = 2*sum - WINDOW
//                          (range -WINDOW..+WINDOW); otherwise dec_out is
//                          the unipolar count 0..WINDOW.
module bitstream_decimator
  import decimator_pkg::*;
#(
  parameter int WINDOW = DEFAULT_WINDOW,
  parameter int OUT_W  = DEFAULT_OUT_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    stream_in,
  output logic signed [OUT_W-1:0] dec_out
);

  localparam int SW = sum_width(WINDOW);

  logic          oldest;
  logic [SW-1:0] sum_p0;
  logic [SW-1:0] sum_next;

  bit_delay_line #(
    .WINDOW (WINDOW)
  ) u_line (
    .clk    (clk),
    .clr    (rst_n),
    .din    (stream_in),
    .oldest (oldest)
  );

  // Maps the window count onto the output level.
  function automatic logic signed [OUT_W-1:0] to_level(input logic [SW-1:0] s);
    logic [OUT_W-1:0] u;
    u = OUT_W'(s);
`ifdef DECIMATOR_BIPOLAR_EN
    return signed'((u << 1) - OUT_W'(WINDOW));
`else
    return signed'(u);
`endif
  endfunction

  // The sum stays within 0..WINDOW because it always equals the popcount of
  // the line, so the modular add/subtract never wraps.
  always_comb begin
    sum_next = sum_p0 + SW'(stream_in) - SW'(oldest);
  end

  // Stage p0: running sum and output level
  always_ff @(posedge clk) begin
    if (rst_n) begin
      sum_p0  <= '0;
      dec_out <= '0;
    end else begin
      sum_p0  <= sum_next;
      dec_out <= to_level(sum_next);
    end
  end

endmodule

// File: tb/tb_bitstream_decimator.sv
// tb_bitstream_decimator
// Scoreboard bench for bitstream_decimator (WINDOW=256, OUT_W=16).
// Each driven sample pushes the reference level into a queue; the value is
// popped and compared once the edge that samples it has passed.
module tb_bitstream_decimator;

  localparam int WINDOW = 256;
  localparam int OUT_W  = 16;
`ifdef DECIMATOR_BIPOLAR_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif

  logic                    clk;
  logic                    rst_n;
  logic                    stream_in;
  logic signed [OUT_W-1:0] dec_out;

  bitstream_decimator #(
    .WINDOW (WINDOW),
    .OUT_W  (OUT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stream_in (stream_in),
    .dec_out   (dec_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Reference model state
  int hist[$];
  int msum;
  int exp_q[$];
  int prev_out;
  bit prev_ok;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act == exp) begin
      n_pass++;
    end else begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int lvl(input int cnt);
`ifdef DECIMATOR_BIPOLAR_EN
    return 2 * cnt - WINDOW;
`else
    return cnt;
`endif
  endfunction

  task automatic model_clear();
    hist.delete();
    for (int i = 0; i < WINDOW; i++) hist.push_back(0);
    msum = 0;
  endtask

  // Drive one sample (or a reset cycle), advance one edge, compare.
  task automatic drive(input logic b, input logic r, input string tag);
    int e;
    int got;
    stream_in = b;
    rst_n     = r;
    if (r) begin
      model_clear();
      e = 0;
    end else begin
      int old;
      old = hist.pop_back();
      hist.push_front(int'(b));
      msum = msum + int'(b) - old;
      e = lvl(msum);
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = int'(dec_out);
    chk(tag, got, exp_q.pop_front());
    // Step property: only meaningful between two non-reset cycles
    if (!r && prev_ok) begin
      int d;
      d = got - prev_out;
      if (d < 0) d = -d;
      chk({tag, "_step"}, int'(d <= STEP), 1);
    end
    prev_out = got;
    prev_ok  = !r;
  endtask

  int cyc;
  int reach;
  bit hit191;
  bit inrange;
  int acc;
  logic y;

  initial begin
    rst_n     = 1'b1;
    stream_in = 1'b0;
    prev_ok   = 1'b0;
    prev_out  = 0;
    model_clear();

    // Reset holds output at 0 despite stream_in=1
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, "rst_hold");
    chk("rst_zero", int'(dec_out), 0);

    // Constant ones: ramp to full, then hold without wrap
    for (int i = 0; i < WINDOW; i++) drive(1'b1, 1'b0, "ones_ramp");
    chk("ones_full", int'(dec_out), lvl(WINDOW));
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, "ones_hold");
    chk("ones_nowrap", int'(dec_out), lvl(WINDOW));

    // Constant zeros drain to empty
    for (int i = 0; i < WINDOW; i++) drive(1'b0, 1'b0, "zeros_ramp");
    chk("zeros_empty", int'(dec_out), lvl(0));
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, "zeros_hold");

    // Pattern 1110
    drive(1'b0, 1'b1, "rst_pat");
    hit191 = 1'b0;
    for (int i = 0; i < WINDOW; i++) begin
      drive((i % 4) != 3, 1'b0, "pat_ramp");
      if (int'(dec_out) == lvl(191)) hit191 = 1'b1;
    end
    chk("pat_192", int'(dec_out), lvl(192));
    chk("pat_hit191", int'(hit191), 1);
    inrange = 1'b1;
    for (int i = 0; i < 64; i++) begin
      drive((i % 4) != 3, 1'b0, "pat_steady");
      if (int'(dec_out) < lvl(191) || int'(dec_out) > lvl(193)) inrange = 1'b0;
    end
    chk("pat_range", int'(inrange), 1);

    // First-order sigma-delta modulator at +0.5 FS
    drive(1'b0, 1'b1, "rst_sd");
    acc   = 0;
    reach = -1;
    for (cyc = 1; cyc <= 1000; cyc++) begin
      y   = (acc >= 0);
      acc = acc + 16384 - (y ? 32768 : -32768);
      drive(y, 1'b0, "sd_loop");
      if (int'(dec_out) == lvl(191)) begin
        reach = cyc;
        break;
      end
    end
    chk("sd_reached", int'(reach > 0), 1);
    chk("sd_within_300", int'(reach > 0 && reach <= 300), 1);

    // Mid-run reset at 150 clears all history
    drive(1'b0, 1'b1, "rst_mid0");
    reach = -1;
    for (cyc = 1; cyc <= 400; cyc++) begin
      drive(1'b1, 1'b0, "mid_ramp");
      if (int'(dec_out) == lvl(150)) begin
        reach = cyc;
        break;
      end
    end
    chk("mid_reach150", reach, 150);
    drive(1'b1, 1'b1, "mid_rst");
    chk("mid_rst_zero", int'(dec_out), 0);
    for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, "mid_restart");
    chk("mid_restart20", int'(dec_out), lvl(20));
    for (int i = 0; i < WINDOW; i++) drive(1'b0, 1'b0, "mid_drain");
    chk("mid_drain0", int'(dec_out), lvl(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
